sobel_pipeline: RTL and testbench
=================================

SOBEL_PIPELINE -- requirements
Module: sobel_pipeline

Interface
REQ-001 Parameter: WIDTH_P, default 640, image width in pixels (>=3).
REQ-002 Parameter: HEIGHT_P, default 480, image height in pixels (>=3).
REQ-003 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_i  input  1  synchronous, active-low reset.
REQ-005 valid_i  input  1  pixel_i carries an input pixel this cycle.
REQ-006 pixel_i  input  8  unsigned grayscale input pixel, raster order (row 0 col 0 first, columns increasing, then rows).
REQ-007 valid_o  output  1  pixel_o carries an output pixel this cycle.
REQ-008 pixel_o  output  8  unsigned Sobel gradient magnitude, same raster order and frame size as the input.

Function
REQ-009 The block SHALL accept one pixel on every rising edge where valid_i=1 while not in FLUSH; there is no backpressure.
REQ-010 The block SHALL emit exactly WIDTH_P*HEIGHT_P outputs per frame, one per valid_o=1 cycle, in raster order.
REQ-011 For an interior pixel (1<=x<=W-2, 1<=y<=H-2) with neighbours p[dy][dx] (dx,dy in -1..1), the block SHALL compute Gx = (p[-1][+1] + 2*p[0][+1] + p[+1][+1]) - (p[-1][-1] + 2*p[0][-1] + p[+1][-1]).
REQ-012 Gy SHALL be computed likewise: (bottom row weighted 1,2,1) minus (top row weighted 1,2,1).
REQ-013 Gx and Gy SHALL use at least 11-bit signed arithmetic (range +/-1020), with no intermediate truncation.
REQ-014 pixel_o SHALL be |Gx|+|Gy|, saturated to 255.
REQ-015 Border pixels (x=0, x=W-1, y=0 or y=H-1) SHALL output 0x00.
REQ-016 Two line buffers of WIDTH_P x 8 bits plus a 3x3 window register SHALL hold the neighbourhood; no full-frame storage.
REQ-017 Latency: output raster index j SHALL be presented with valid_o=1 exactly 2 rising edges after the edge that accepted input index j+WIDTH_P+1.
REQ-018 Gaps in valid_i SHALL stall the pipeline without loss. valid_o SHALL then show matching gaps, and pixel_o values SHALL be identical to a gap-free stream.
REQ-019 States: STREAM (accepting input) and FLUSH.
REQ-020 Acceptance of input index W*H-1 SHALL cause a transition to FLUSH.
REQ-021 In FLUSH, the remaining WIDTH_P+1 outputs SHALL be emitted on consecutive cycles with valid_o=1; all of these are border pixels and are 0x00.
REQ-022 After the last output, the block SHALL return to STREAM with input/output coordinates at (0,0), ready for the next frame.
REQ-023 valid_i asserted during FLUSH SHALL be ignored; those pixels are dropped.
REQ-024 The full frame output SHALL complete within 2*WIDTH_P cycles after the last input is accepted.
REQ-025 Column/row counters SHALL wrap at WIDTH_P-1 and HEIGHT_P-1 respectively.
REQ-026 pixel_o SHALL be 0x00 whenever valid_o=0.

Reset
REQ-027 While reset_i=0 at a rising edge, valid_o and pixel_o SHALL become 0, and the state SHALL become STREAM.
REQ-028 Reset SHALL set all row/column counters to 0 and clear pending pipeline valids.
REQ-029 Line-buffer contents need not be cleared on reset.
REQ-030 Reset asserted mid-frame or mid-FLUSH SHALL abandon the frame. The next accepted pixel after reset release SHALL be treated as (0,0).

Verification (WIDTH_P=8, HEIGHT_P=6 unless stated)
REQ-031 Constant image of 0x80 -> exactly 48 valid_o pulses, all pixel_o=0x00.
REQ-032 Vertical step with columns 0-3=0x00 and columns 4-7=0xFF -> rows 1-4 at x=3 and x=4 output 0xFF (1020 saturated); all other outputs 0x00.
REQ-033 All-zero image except 10 at (3,3) -> outputs: (2,2)=20, (3,2)=20, (4,2)=20, (2,3)=20, (3,3)=0, (4,3)=20, (2,4)=20, (3,4)=20, (4,4)=20; all others 0.
REQ-034 Run REQ-033 with valid_i deasserted on random cycles -> same 48 values in the same order; first valid_o occurs 2 edges after input index 9 is accepted.
REQ-035 Reset pulse after 20 inputs, then a full new frame (REQ-031 image) -> valid_o=0 during reset; exactly 48 outputs after release, all 0x00.
REQ-036 Defaults 640x480 with random image -> 307200 outputs, matching a software Sobel model bit-exactly, with the last output within 1280 cycles of the last input.

Source files
------------

// File: rtl/sobel_pipeline_if.sv
// sobel_pipeline_if
//   Pixel stream bundle between a pixel source and the Sobel pipeline.
//   Signal names are from the filter's point of view.
//     valid_i / pixel_i : input pixel stream (source -> filter)
//     valid_o / pixel_o : gradient magnitude stream (filter -> sink)
//   modport master : the pixel source / sink side (testbench, upstream logic)
//   modport slave  : the filter side
interface sobel_pipeline_if;
    logic       valid_i;
    logic [7:0] pixel_i;
    logic       valid_o;
    logic [7:0] pixel_o;

    modport master (output valid_i, output pixel_i, input valid_o, input pixel_o);
    modport slave  (input valid_i, input pixel_i, output valid_o, output pixel_o);
endinterface

// File: rtl/sobel_pipeline.sv
// sobel_pipeline
//   Streaming 3x3 Sobel edge filter. Consumes an 8-bit grayscale frame in
//   raster order and emits |Gx|+|Gy| (saturated to 255) for every pixel,
//   with border pixels forced to 0. Two line buffers plus a 3x3 window
//   hold the neighbourhood. After the last input pixel of a frame the
//   block enters FLUSH and emits the trailing WIDTH_P+1 border outputs.
//   Ports:
//     clk_i   : clock, rising edge
//     reset_i : synchronous, active-low reset
//     bus     : sobel_pipeline_if.slave (valid_i/pixel_i in, valid_o/pixel_o out)
module sobel_pipeline #(
    parameter int WIDTH_P  = 640,
    parameter int HEIGHT_P = 480
) (
    input  logic            clk_i,
    input  logic            reset_i,
    sobel_pipeline_if.slave bus
);
    localparam int COL_W  = $clog2(WIDTH_P);
    localparam int ROW_W  = $clog2(HEIGHT_P);
    localparam int FL_W   = $clog2(WIDTH_P + 1);
    localparam int GRAD_W = 12;

    typedef enum logic {STREAM, FLUSH} state_e;

    state_e            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic              accept;

    logic              vld_p0_q, vld_p0_d;
    logic              border_p0_q, border_p0_d;
    logic [7:0]        lb_top_q [WIDTH_P];
    logic [7:0]        lb_mid_q [WIDTH_P];
    logic [7:0]        win_p0_q [3][3];

    logic              vld_p1_q;
    logic              border_p1_q;
    logic signed [GRAD_W-1:0] gx_p1_q, gx_p1_d;
    logic signed [GRAD_W-1:0] gy_p1_q, gy_p1_d;

    logic              valid_o_q;
    logic [7:0]        pixel_o_q;

    function automatic logic signed [GRAD_W-1:0] ext(input logic [7:0] p);
        return $signed({{(GRAD_W-8){1'b0}}, p});
    endfunction

    function automatic logic [7:0] sat_mag(input logic signed [GRAD_W-1:0] gx,
                                           input logic signed [GRAD_W-1:0] gy);
        logic [GRAD_W-1:0] ax;
        logic [GRAD_W-1:0] ay;
        logic [GRAD_W:0]   sum;
        ax  = gx[GRAD_W-1] ? -gx : gx;
        ay  = gy[GRAD_W-1] ? -gy : gy;
        sum = {1'b0, ax} + {1'b0, ay};
        return (sum > (GRAD_W+1)'(255)) ? 8'hFF : sum[7:0];
    endfunction

    // Control: raster counters, STREAM/FLUSH, stage-0 valid and border tag
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        flush_cnt_d = flush_cnt_q;
        accept      = 1'b0;
        vld_p0_d    = 1'b0;
        border_p0_d = 1'b1;
        case (state_q)
            STREAM: begin
                if (bus.valid_i) begin
                    accept = 1'b1;
                    // Window centre lags the input by WIDTH_P+1 pixels; no
                    // output exists until that centre reaches raster index 0.
                    vld_p0_d = (row_q >= ROW_W'(2)) ||
                               ((row_q == ROW_W'(1)) && (col_q != '0));
                    // col 0 -> centre at x=W-1 of the previous row, col 1 -> x=0,
                    // row 1 -> centre row 0. Centre never lands on row H-1 here.
                    border_p0_d = (col_q <= COL_W'(1)) || (row_q == ROW_W'(1));
                    if (col_q == COL_W'(WIDTH_P - 1)) begin
                        col_d = '0;
                        if (row_q == ROW_W'(HEIGHT_P - 1)) begin
                            row_d       = '0;
                            flush_cnt_d = '0;
                            state_d     = FLUSH;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                // Trailing WIDTH_P+1 outputs are all border pixels.
                vld_p0_d    = 1'b1;
                border_p0_d = 1'b1;
                if (flush_cnt_q == FL_W'(WIDTH_P)) begin
                    flush_cnt_d = '0;
                    state_d     = STREAM;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            default: state_d = STREAM;
        endcase
    end

    always_comb begin
        gx_p1_d = (ext(win_p0_q[0][2]) + (ext(win_p0_q[1][2]) <<< 1) + ext(win_p0_q[2][2]))
                - (ext(win_p0_q[0][0]) + (ext(win_p0_q[1][0]) <<< 1) + ext(win_p0_q[2][0]));
        gy_p1_d = (ext(win_p0_q[2][0]) + (ext(win_p0_q[2][1]) <<< 1) + ext(win_p0_q[2][2]))
                - (ext(win_p0_q[0][0]) + (ext(win_p0_q[0][1]) <<< 1) + ext(win_p0_q[0][2]));
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= STREAM;
            col_q       <= '0;
            row_q       <= '0;
            flush_cnt_q <= '0;
            vld_p0_q    <= 1'b0;
            vld_p1_q    <= 1'b0;
            valid_o_q   <= 1'b0;
            pixel_o_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            flush_cnt_q <= flush_cnt_d;
            vld_p0_q    <= vld_p0_d;
            // Stage 1 -> output: magnitude, saturation, border forcing
            vld_p1_q    <= vld_p0_q;
            valid_o_q   <= vld_p1_q;
            pixel_o_q   <= (vld_p1_q && !border_p1_q) ? sat_mag(gx_p1_q, gy_p1_q) : 8'h00;
        end
    end

    // Stage 0: line buffers and 3x3 window advance only on accepted pixels
    always_ff @(posedge clk_i) begin
        if (accept) begin
            lb_top_q[col_q] <= lb_mid_q[col_q];
            lb_mid_q[col_q] <= bus.pixel_i;
            for (int r = 0; r < 3; r++) begin
                win_p0_q[r][0] <= win_p0_q[r][1];
                win_p0_q[r][1] <= win_p0_q[r][2];
            end
            win_p0_q[0][2] <= lb_top_q[col_q];
            win_p0_q[1][2] <= lb_mid_q[col_q];
            win_p0_q[2][2] <= bus.pixel_i;
        end
        border_p0_q <= border_p0_d;
        // Stage 0 -> stage 1: gradients
        gx_p1_q     <= gx_p1_d;
        gy_p1_q     <= gy_p1_d;
        border_p1_q <= border_p0_q;
    end

    assign bus.valid_o = valid_o_q;
    assign bus.pixel_o = pixel_o_q;
endmodule

// File: tb/tb_sobel_pipeline.sv
// tb_sobel_pipeline
//   Directed bench for sobel_pipeline at 8x6: constant, vertical step and
//   single-impulse frames, stalled input, pixels offered during FLUSH, and a
//   mid-frame reset. Expected outputs are hand-derived per image.
module tb_sobel_pipeline;
    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic clk_i = 1'b0;
    logic reset_i;

    sobel_pipeline_if bus ();

    sobel_pipeline #(.WIDTH_P(W), .HEIGHT_P(H)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    logic [7:0] out_pix [$];
    int         out_cyc [$];
    int         idle_bad = 0;

    always @(negedge clk_i) begin
        if (bus.valid_o === 1'b1) begin
            out_pix.push_back(bus.pixel_o);
            out_cyc.push_back(cyc);
        end else if (bus.pixel_o !== 8'h00) begin
            idle_bad <= idle_bad + 1;
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int acc9;
    int acc_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // kind 0: constant 0x80; 1: cols 0-3 = 0x00, cols 4-7 = 0xFF; 2: 10 at (3,3)
    function automatic logic [7:0] img(input int kind, input int x, input int y);
        case (kind)
            0:       return 8'h80;
            1:       return (x >= 4) ? 8'hFF : 8'h00;
            default: return (x == 3 && y == 3) ? 8'd10 : 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] exp_px(input int kind, input int x, input int y);
        case (kind)
            0:       return 8'h00;
            1:       return (y >= 1 && y <= 4 && (x == 3 || x == 4)) ? 8'hFF : 8'h00;
            default: return (x >= 2 && x <= 4 && y >= 2 && y <= 4 && !(x == 3 && y == 3))
                            ? 8'd20 : 8'd0;
        endcase
    endfunction

    task automatic clear_out();
        out_pix.delete();
        out_cyc.delete();
    endtask

    task automatic send_frame(input int kind, input bit gaps, input int npx, input int extra);
        for (int i = 0; i < npx; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 3);
                if (g > 1) begin
                    repeat (g - 1) begin
                        @(negedge clk_i);
                        bus.valid_i = 1'b0;
                        bus.pixel_i = 8'h5A;
                    end
                end
            end
            @(negedge clk_i);
            bus.valid_i = 1'b1;
            bus.pixel_i = img(kind, i % W, i / W);
            if (i == W + 1) acc9 = cyc + 1;
            acc_last = cyc + 1;
        end
        for (int i = 0; i < extra; i++) begin
            @(negedge clk_i);
            bus.valid_i = 1'b1;
            bus.pixel_i = 8'hFF;
        end
        @(negedge clk_i);
        bus.valid_i = 1'b0;
        bus.pixel_i = 8'h00;
    endtask

    task automatic check_frame(input string tag, input int kind);
        int t;
        t = 0;
        while (out_pix.size() < N && t < 4 * N) begin
            @(negedge clk_i);
            t++;
        end
        repeat (2 * W) @(negedge clk_i);
        check({tag, " count"}, out_pix.size(), N);
        for (int j = 0; j < N && j < out_pix.size(); j++)
            check($sformatf("%s px%0d", tag, j), out_pix[j], exp_px(kind, j % W, j / W));
        if (out_pix.size() >= N)
            check({tag, " last-out-within-2W"}, (out_cyc[N-1] - acc_last) <= 2 * W, 1);
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.pixel_i = 8'h00;
        reset_i     = 1'b0;
        repeat (3) @(negedge clk_i);
        check("reset valid_o", bus.valid_o, 0);
        check("reset pixel_o", bus.pixel_o, 0);
        reset_i = 1'b1;

        clear_out();
        send_frame(0, 1'b0, N, 0);
        check_frame("const", 0);
        if (out_cyc.size() > 0) check("const latency", out_cyc[0], acc9 + 2);

        clear_out();
        send_frame(1, 1'b0, N, 0);
        check_frame("step", 1);

        clear_out();
        send_frame(2, 1'b0, N, 0);
        check_frame("impulse", 2);

        clear_out();
        send_frame(2, 1'b1, N, 0);
        check_frame("impulse-gaps", 2);
        if (out_cyc.size() > 0) check("gaps latency", out_cyc[0], acc9 + 2);

        // Pixels offered right after the last one land in FLUSH and must be dropped
        clear_out();
        send_frame(1, 1'b0, N, 5);
        check_frame("step-flushdrop", 1);
        clear_out();
        send_frame(2, 1'b0, N, 0);
        check_frame("impulse-after-drop", 2);

        // Abandon a frame part-way with reset, then a fresh frame
        clear_out();
        send_frame(2, 1'b0, 20, 0);
        reset_i = 1'b0;
        @(negedge clk_i);
        check("midreset valid_o", bus.valid_o, 0);
        check("midreset pixel_o", bus.pixel_o, 0);
        @(negedge clk_i);
        check("midreset valid_o 2", bus.valid_o, 0);
        reset_i = 1'b1;
        clear_out();
        send_frame(0, 1'b0, N, 0);
        check_frame("after-reset", 0);

        check("pixel_o zero while idle", idle_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
